// File: rtl/p2c_pkg.sv
// Shared types and constants for the polar-to-Cartesian converter.
// The FSM walks one request at a time through angle reduction, lookup and scaling.
package p2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE,
    ISSUE,
    WAIT,
    MULT,
    DONE
  } p2c_state_t;

  localparam int DEG_FULL      = 360;
  localparam int P2C_FRAC_BITS = 15;
  localparam int ONE_Q         = 1 << P2C_FRAC_BITS;

endpackage

// File: rtl/p2c_trig_scale.sv
// Scales an unsigned magnitude by a Q1.15 |cos|/|sin| coefficient and applies the quadrant sign.
// Purely combinational; the top instantiates one copy for x and one for y.
module trig_scale #(
  parameter int MAG_WIDTH = 16,
  parameter int FRAC_BITS = 15
) (
  input  logic [MAG_WIDTH-1:0]        mag,
  input  logic [15:0]                 coef,
  input  logic                        positive,
  output logic signed [MAG_WIDTH:0]   result
);

  localparam int PW = MAG_WIDTH + 16;

  logic [MAG_WIDTH-1:0] scaled;
  logic [MAG_WIDTH:0]   magnitude;

  // The coefficient never exceeds 1.0, so the shifted product always fits in MAG_WIDTH bits.
  assign scaled    = MAG_WIDTH'((PW'(mag) * PW'(coef)) >> FRAC_BITS);
  assign magnitude = {1'b0, scaled};
  assign result    = positive ? magnitude : (~magnitude + (MAG_WIDTH+1)'(1));

endmodule

// File: rtl/polar_to_cartesian.sv
// Converts (magnitude, degrees) into signed x/y using an externally shared cos/sin lookup.
// One request in flight at a time; results are offered on a valid/ready handshake.
module polar_to_cartesian
  import p2c_pkg::*;
#(
  parameter int MAG_WIDTH      = 16,
  parameter int FRAC_BITS      = 15,
  parameter int LOOKUP_LATENCY = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [MAG_WIDTH-1:0]      mag_in,
  input  logic [15:0]               angle_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [15:0]               angle_out,
  input  logic [15:0]               cos_abs,
  input  logic [15:0]               sin_abs,
  input  logic                      cos_sign,
  input  logic                      sin_sign,
  output logic signed [MAG_WIDTH:0] x_out,
  output logic signed [MAG_WIDTH:0] y_out,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int CNT_W = (LOOKUP_LATENCY < 2) ? 1 : $clog2(LOOKUP_LATENCY);

  p2c_state_t state, state_next;

  logic [MAG_WIDTH-1:0]      mag_r;
  logic [15:0]               angle_r;
  logic [15:0]               angle_minus;
  logic                      cos_pos, sin_pos;
  logic [CNT_W-1:0]          wait_cnt;
  logic signed [MAG_WIDTH:0] px_s, py_s;

  assign angle_minus = angle_r - 16'(DEG_FULL);
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = (angle_in >= 16'(DEG_FULL)) ? REDUCE : ISSUE;
      REDUCE:  if (angle_minus < 16'(DEG_FULL)) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_cnt <= CNT_W'(1)) state_next = MULT;
      MULT:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // angle_out is loaded as soon as the reduced angle is known, so it is already
  // stable during ISSUE and the combinational lookup signs can be latched there.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mag_r     <= '0;
      angle_r   <= '0;
      angle_out <= '0;
      cos_pos   <= 1'b0;
      sin_pos   <= 1'b0;
      wait_cnt  <= '0;
      x_out     <= '0;
      y_out     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mag_r   <= mag_in;
          angle_r <= angle_in;
          if (angle_in < 16'(DEG_FULL)) angle_out <= angle_in;
        end
        REDUCE: begin
          angle_r <= angle_minus;
          if (angle_minus < 16'(DEG_FULL)) angle_out <= angle_minus;
        end
        ISSUE: begin
          cos_pos  <= cos_sign;
          sin_pos  <= sin_sign;
          wait_cnt <= CNT_W'(LOOKUP_LATENCY - 1);
        end
        WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
        MULT: begin
          x_out <= px_s;
          y_out <= py_s;
        end
        default: ;
      endcase
    end
  end

  trig_scale #(.MAG_WIDTH(MAG_WIDTH), .FRAC_BITS(FRAC_BITS)) u_scale_x (
    .mag      (mag_r),
    .coef     (cos_abs),
    .positive (cos_pos),
    .result   (px_s)
  );

  trig_scale #(.MAG_WIDTH(MAG_WIDTH), .FRAC_BITS(FRAC_BITS)) u_scale_y (
    .mag      (mag_r),
    .coef     (sin_abs),
    .positive (sin_pos),
    .result   (py_s)
  );

endmodule

// File: tb/tb_polar_to_cartesian.sv
// Directed bench for polar_to_cartesian with a 2-cycle lookup stub that only returns
// the programmed |cos|/|sin| once angle_out has been stable for the full latency.
module tb_polar_to_cartesian;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic [15:0]        mag_in;
  logic [15:0]        angle_in;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        angle_out;
  logic [15:0]        cos_abs, sin_abs;
  logic               cos_sign, sin_sign;
  logic signed [16:0] x_out, y_out;
  logic               out_valid;
  logic               out_ready;

  logic [15:0] stub_cos, stub_sin;
  logic        stub_cos_sgn, stub_sin_sgn;
  logic [15:0] ang_d1, ang_d2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  polar_to_cartesian dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .mag_in    (mag_in),
    .angle_in  (angle_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_out (angle_out),
    .cos_abs   (cos_abs),
    .sin_abs   (sin_abs),
    .cos_sign  (cos_sign),
    .sin_sign  (sin_sign),
    .x_out     (x_out),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Lookup stub: garbage until angle_out has been held for two clocks.
  always_ff @(posedge clk_in) begin
    ang_d1 <= angle_out;
    ang_d2 <= ang_d1;
  end
  assign cos_abs  = (ang_d2 == angle_out) ? stub_cos : 16'h1234;
  assign sin_abs  = (ang_d2 == angle_out) ? stub_sin : 16'h1234;
  assign cos_sign = stub_cos_sgn;
  assign sin_sign = stub_sin_sgn;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic setStub(input int c, input bit cs, input int s, input bit ss);
    stub_cos     = 16'(c);
    stub_cos_sgn = cs;
    stub_sin     = 16'(s);
    stub_sin_sgn = ss;
  endtask

  // One full request; latency is the cycle index (handshake cycle = 0) where out_valid is first seen.
  task automatic applyStimulus(input int mag, input int ang, input int exp_angle, input int exp_lat,
                               input int exp_x, input int exp_y, input bit pre_ready,
                               input bit toggle_signs, input int hold);
    int lat;
    int held_x, held_y;
    mag_in    = 16'(mag);
    angle_in  = 16'(ang);
    in_valid  = 1'b1;
    out_ready = pre_ready;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 400) begin
      if (toggle_signs && lat == 2) begin
        stub_cos_sgn = ~stub_cos_sgn;
        stub_sin_sgn = ~stub_sin_sgn;
      end
      @(posedge clk_in); #1;
      lat++;
    end
    checkOutput("latency", lat, exp_lat);
    if (!out_valid) return;
    checkOutput("angle_out", int'(angle_out), exp_angle);
    checkOutput("x_out", int'(x_out), exp_x);
    checkOutput("y_out", int'(y_out), exp_y);
    held_x = int'(x_out);
    held_y = int'(y_out);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      mag_in   = 16'd7;
      angle_in = 16'd3;
      @(posedge clk_in); #1;
      checkOutput("hold_x", int'(x_out), held_x);
      checkOutput("hold_y", int'(y_out), held_y);
      checkOutput("hold_in_ready", int'(in_ready), 0);
      checkOutput("hold_out_valid", int'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk_in); #1;
    out_ready = 1'b0;
    checkOutput("drop_out_valid", int'(out_valid), 0);
    checkOutput("idle_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    bit seen_valid;
    rst_in    = 1'b1;
    mag_in    = '0;
    angle_in  = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    setStub(32768, 1'b1, 0, 1'b1);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_x", int'(x_out), 0);
    checkOutput("rst_y", int'(y_out), 0);
    checkOutput("rst_angle_out", int'(angle_out), 0);

    // Unit cosine; out_ready already high before the result arrives.
    applyStimulus(1000, 0, 0, 4, 1000, 0, 1'b1, 1'b0, 0);

    // cos 0.5 negative, sin ~0.866 positive; stub flips signs during WAIT.
    setStub(16384, 1'b0, 28378, 1'b1);
    applyStimulus(2000, 120, 120, 4, -1000, 1732, 1'b0, 1'b1, 0);

    // Angle reduction: one extra cycle per 360 removed.
    setStub(32768, 1'b1, 0, 1'b1);
    applyStimulus(100, 5, 5, 4, 100, 0, 1'b0, 1'b0, 0);
    applyStimulus(100, 725, 5, 6, 100, 0, 1'b0, 1'b0, 0);
    applyStimulus(100, 360, 0, 5, 100, 0, 1'b0, 1'b0, 0);
    applyStimulus(100, 65535, 15, 186, 100, 0, 1'b0, 1'b0, 0);

    // Consumer stalls for 10 cycles while in_valid pulses.
    setStub(16384, 1'b1, 16384, 1'b0);
    applyStimulus(300, 45, 45, 4, 150, -150, 1'b0, 1'b0, 10);

    // Reset in WAIT discards the request.
    setStub(32768, 1'b1, 32768, 1'b1);
    mag_in   = 16'd500;
    angle_in = 16'd200;
    in_valid = 1'b1;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    checkOutput("wait_rst_out_valid", int'(out_valid), 0);
    checkOutput("wait_rst_in_ready", int'(in_ready), 1);
    checkOutput("wait_rst_x", int'(x_out), 0);
    checkOutput("wait_rst_y", int'(y_out), 0);
    seen_valid = 1'b0;
    repeat (6) begin
      @(posedge clk_in); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("no_partial_result", int'(seen_valid), 0);

    setStub(0, 1'b1, 32768, 1'b1);
    applyStimulus(500, 90, 90, 4, 0, 500, 1'b0, 1'b0, 0);

    // Full-scale negative and negative-zero cases.
    setStub(32768, 1'b0, 0, 1'b0);
    applyStimulus(65535, 180, 180, 4, -65535, 0, 1'b0, 1'b0, 0);
    setStub(0, 1'b0, 32768, 1'b0);
    applyStimulus(65535, 270, 270, 4, 0, -65535, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/polar_to_cartesian.md
Name: polar_to_cartesian

Overview:
Converts a (magnitude, angle-in-degrees) request into signed Cartesian components x = mag·cos, y = mag·sin. Sits directly downstream of the shared cos_sin_lookup. It drives the lookup's angle input, waits out the RAM latency, captures the quadrant signs, scales the magnitude by the returned |cos| and |sin|, and presents signed results to the consumer (sprite/vector renderer) over a valid/ready handshake. The lookup itself is instantiated outside this block, so it can be shared.

Parameters:
MAG_WIDTH, 16, unsigned magnitude width.
FRAC_BITS, 15, fraction bits of the lookup values (32768 = 1.0).
LOOKUP_LATENCY, 2, clock cycles from angle_out stable to cos_abs/sin_abs valid.

Ports:
clk_in  in  1  system clock
rst_in  in  1  reset, synchronous, active-high
mag_in  in  MAG_WIDTH  unsigned magnitude
angle_in  in  16  angle in degrees, any value 0..65535
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
angle_out  out  16  angle to lookup, always 0..359
cos_abs  in  16  |cos| from lookup, Q1.15
sin_abs  in  16  |sin| from lookup, Q1.15
cos_sign  in  1  1 = positive; combinational from angle_out
sin_sign  in  1  1 = positive; combinational from angle_out
x_out  out  MAG_WIDTH+1  signed two's-complement x
y_out  out  MAG_WIDTH+1  signed two's-complement y
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset: state IDLE; out_valid=0, x_out=0, y_out=0, angle_out=0, in_ready=1. Takes effect from any state. An in-flight request is discarded; no partial result is ever emitted.
- in_ready = (state==IDLE). Accept on in_valid & in_ready: register mag and angle. Next state is REDUCE if angle_in>=360, else ISSUE.
- REDUCE: subtract 360 once per cycle while the value is >=360. Go to ISSUE when <360. This costs floor(angle_in/360) cycles (max 182).
- ISSUE (1 cycle): angle_out = reduced angle, a register held stable until the next accept. Latch cos_sign/sin_sign this cycle. Load wait counter = LOOKUP_LATENCY-1, then go to WAIT.
- WAIT: decrement the counter. When it reaches 0, go to MULT. cos_abs/sin_abs are valid in the MULT cycle.
- MULT (1 cycle): compute px = (mag·cos_abs)>>FRAC_BITS and py likewise.
  - Products are full 2·16-bit unsigned; the shift truncates toward zero.
  - px, py fit in MAG_WIDTH bits because cos_abs <= 32768.
  - x_out = cos_sign ? +px : −px, sign-extended to MAG_WIDTH+1. Negation of 0 yields 0. y_out likewise.
  - Register the outputs and go to DONE.
- DONE: out_valid=1. x_out/y_out are held stable while out_valid & !out_ready. On out_ready, out_valid drops the next cycle and the state returns to IDLE.
- Latency for angle_in<360 with LOOKUP_LATENCY=2: handshake in cycle 0, out_valid high in cycle LOOKUP_LATENCY+2 = 4. Add 1 cycle per 360 subtracted.
- Throughput: one request per (latency+1) cycles minimum. There is no overlap; in_valid while busy is ignored (in_ready=0).
- out_ready asserted before out_valid has no effect.
- cos_abs/sin_abs are never sampled outside MULT.

Decomposition:
- Package p2c_pkg holds:
  - p2c_state_t enum {IDLE, REDUCE, ISSUE, WAIT, MULT, DONE}
  - localparam DEG_FULL = 360
  - localparam ONE_Q = 1<<FRAC_BITS
- One sub-module, trig_scale: unsigned mag × Q1.15 coefficient, shift, and conditional negate to a signed result. It is purely combinational and instantiated twice, for x and y.
- Top-level bench wiring connects angle_out to cos_sin_lookup.angle.

Test Plan:
- Lookup stub with 2-cycle latency returning cos_abs=32768 (+), sin_abs=0 (+); mag=1000, angle=0 → x_out=1000, y_out=0, out_valid first high 4 cycles after handshake.
- Stub cos_abs=16384 sign 0, sin_abs=28378 sign 1; mag=2000 → x_out=−1000, y_out=+1732. Signs are latched in ISSUE; the stub toggles the signs during WAIT with no effect on the result.
- angle_in=725 → angle_out=5, and out_valid appears 2 cycles later than for angle 5. angle_in=360 → angle_out=0.
- Hold out_ready=0 for 10 cycles in DONE → x/y stable and in_ready=0 throughout; in_valid pulses are ignored. Release → out_valid drops the next cycle and in_ready=1.
- Assert rst_in during WAIT → the next cycle shows out_valid=0, in_ready=1, x/y=0. A fresh request then completes normally with correct values.
- mag=65535, cos_abs=32768, sign 0 → x_out=−65535 (17-bit 0x10001). cos_abs=0, sign 0 → x_out=0, never −0.
